// File: rtl/sbc_pkg.sv
// rtl/sbc_pkg.sv - shared types and saturating shift for the stochastic-to-binary converter
package sbc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sbc_state_e;
  typedef enum logic {MODE_COUNT, MODE_PP} sbc_mode_e;

  // Left-shift a ones count and clamp to the largest w-bit value (all-ones streams hit 2^w).
  function automatic logic [31:0] sat_shift(input logic [31:0] x, input int unsigned sh,
                                            input int unsigned w);
    logic [63:0] y;
    logic [63:0] maxv;
    y    = {32'd0, x} << sh;
    maxv = (64'd1 << w) - 64'd1;
    if (y > maxv) y = maxv;
    return y[31:0];
  endfunction

endpackage

// File: rtl/sbc_multi_if.sv
// rtl/sbc_multi_if.sv - control, bitstream and result bundle of the converter
interface sbc_multi_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int LW = $clog2(WIDTH + 1);

  logic                   start;
  logic                   mode;
  logic [LW-1:0]          len_log2;
  logic                   bits_valid;
  logic [NCH-1:0]         bits;
  logic                   stop;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [NCH*WIDTH-1:0]   out_value;
  logic [WIDTH:0]         out_len;
  logic                   out_early;

  modport master (
    output start, mode, len_log2, bits_valid, bits, stop, out_ready,
    input  busy, out_valid, out_value, out_len, out_early
  );

  modport slave (
    input  start, mode, len_log2, bits_valid, bits, stop, out_ready,
    output busy, out_valid, out_value, out_len, out_early
  );
endinterface

// File: rtl/sbc_chan.sv
// rtl/sbc_chan.sv - one channel: ones counter, power-of-two snapshot and result register
module sbc_chan
  import sbc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             accept_i,
  input  logic             bit_i,
  input  logic             snap_en_i,
  input  logic [LW-1:0]    snap_sh_i,
  input  logic             fin_i,
  input  logic [LW-1:0]    fin_sh_i,
  input  logic             use_snap_i,
  output logic [WIDTH-1:0] value_o
);
  localparam int NW = WIDTH + 1;

  logic [NW-1:0]    ones_q, ones_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] value_q, value_d;

  // The snapshot and result both see the count including the bit accepted this cycle.
  always_comb begin
    ones_d  = ones_q;
    snap_d  = snap_q;
    value_d = value_q;
    if (clear_i) begin
      ones_d = '0;
      snap_d = '0;
    end else begin
      if (accept_i) ones_d = ones_q + NW'(bit_i);
      if (snap_en_i) snap_d = WIDTH'(sat_shift(32'(ones_d), 32'(snap_sh_i), 32'(WIDTH)));
      if (fin_i) begin
        value_d = use_snap_i ? snap_d
                             : WIDTH'(sat_shift(32'(ones_d), 32'(fin_sh_i), 32'(WIDTH)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q  <= '0;
      snap_q  <= '0;
      value_q <= '0;
    end else begin
      ones_q  <= ones_d;
      snap_q  <= snap_d;
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/sbc_multi.sv
// rtl/sbc_multi.sv - multi-channel stochastic-to-binary converter with stop/result handshake
module sbc_multi
  import sbc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input logic        clk,
  input logic        rst_n,
  sbc_multi_if.slave bus
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int NW = WIDTH + 1;

  sbc_state_e state_q, state_d;
  sbc_mode_e  mode_q, mode_d;
  logic [LW-1:0] l_q, l_d, l_in, snap_sh, fin_sh;
  logic [NW-1:0] n_q, n_d, len_q, len_d, n_inc;
  logic          early_q, early_d;
  logic          clear, accept, complete, finish, use_snap, snap_en;
  logic [NCH*WIDTH-1:0] value_w;

  assign l_in   = (bus.len_log2 > LW'(WIDTH)) ? LW'(WIDTH) : bus.len_log2;
  assign n_inc  = n_q + NW'(1);
  assign fin_sh = LW'(WIDTH) - l_q;

  always_comb begin
    accept   = (state_q == RUN) && bus.bits_valid;
    complete = accept && (n_inc == (NW'(1) << l_q));
    finish   = (state_q == RUN) && (complete || bus.stop);
    use_snap = (mode_q == MODE_PP) && !complete;
    snap_en  = 1'b0;
    snap_sh  = '0;
    for (int k = 0; k <= WIDTH; k++) begin
      if (accept && (n_inc == (NW'(1) << k))) begin
        snap_en = 1'b1;
        snap_sh = LW'(WIDTH - k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    l_d     = l_q;
    n_d     = n_q;
    len_d   = len_q;
    early_d = early_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: clear = bus.start;
      RUN: begin
        if (accept) n_d = n_inc;
        if (finish) begin
          state_d = DONE;
          len_d   = accept ? n_inc : n_q;
          early_d = !complete;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          clear   = bus.start;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = RUN;
      mode_d  = sbc_mode_e'(bus.mode);
      l_d     = l_in;
      n_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_COUNT;
      l_q     <= '0;
      n_q     <= '0;
      len_q   <= '0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      l_q     <= l_d;
      n_q     <= n_d;
      len_q   <= len_d;
      early_q <= early_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    sbc_chan #(.WIDTH(WIDTH), .LW(LW)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (clear),
      .accept_i   (accept),
      .bit_i      (bus.bits[c]),
      .snap_en_i  (snap_en),
      .snap_sh_i  (snap_sh),
      .fin_i      (finish),
      .fin_sh_i   (fin_sh),
      .use_snap_i (use_snap),
      .value_o    (value_w[c*WIDTH +: WIDTH])
    );
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_value = value_w;
  assign bus.out_len   = len_q;
  assign bus.out_early = early_q;

endmodule

// File: tb/tb_sbc_multi.sv
// tb/tb_sbc_multi.sv - directed self-checking bench for sbc_multi
module tb_sbc_multi;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sbc_multi_if #(.WIDTH(8), .NCH(4)) bus ();

  sbc_multi #(.WIDTH(8), .NCH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic m, input logic [3:0] l);
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.len_log2 = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic drive_bit(input logic [3:0] b, input logic v, input logic s);
    bus.bits       = b;
    bus.bits_valid = v;
    bus.stop       = s;
    tick();
    bus.bits       = 4'b0000;
    bus.bits_valid = 1'b0;
    bus.stop       = 1'b0;
  endtask

  task automatic ack();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  logic [3:0] b;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.len_log2   = 4'd0;
    bus.bits_valid = 1'b0;
    bus.bits       = 4'b0000;
    bus.stop       = 1'b0;
    bus.out_ready  = 1'b0;
    #3;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_value", 64'(bus.out_value), 64'd0);
    check("reset_len", 64'(bus.out_len), 64'd0);
    check("reset_early", 64'(bus.out_early), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // COUNT L=4: ch0 5 ones, ch1 none, ch2 all, ch3 alternating
    start_conv(1'b0, 4'd4);
    check("t1_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 16; i++) begin
      b = {i[0], 1'b1, 1'b0, (i < 5)};
      drive_bit(b, 1'b1, 1'b0);
      if (i == 14) check("t1_not_yet", 64'(bus.out_valid), 64'd0);
    end
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_busy_lo", 64'(bus.busy), 64'd0);
    check("t1_value", 64'(bus.out_value), 64'h80FF0050);
    check("t1_len", 64'(bus.out_len), 64'd16);
    check("t1_early", 64'(bus.out_early), 64'd0);
    tick();
    check("t1_hold", 64'(bus.out_value), 64'h80FF0050);
    ack();
    check("t1_ack", 64'(bus.out_valid), 64'd0);

    // PP then COUNT, L=8, stop with the 11th bit
    for (int m = 1; m >= 0; m--) begin
      start_conv(m[0], 4'd8);
      for (int i = 0; i < 11; i++) begin
        b = {1'b0, 1'b1, (i < 3 || i == 10), 1'b0};
        drive_bit(b, 1'b1, (i == 10));
      end
      check("t2_valid", 64'(bus.out_valid), 64'd1);
      check("t2_value", 64'(bus.out_value), (m == 1) ? 64'h00FF6000 : 64'h000B0400);
      check("t2_len", 64'(bus.out_len), 64'd11);
      check("t2_early", 64'(bus.out_early), 64'd1);
      ack();
    end

    // saturation: L=3 all ones, then L=0 single one
    start_conv(1'b0, 4'd3);
    for (int i = 0; i < 8; i++) drive_bit(4'b1111, 1'b1, 1'b0);
    check("t3_value", 64'(bus.out_value), 64'hFFFFFFFF);
    check("t3_len", 64'(bus.out_len), 64'd8);
    ack();
    start_conv(1'b1, 4'd0);
    drive_bit(4'b0001, 1'b1, 1'b0);
    check("t3b_valid", 64'(bus.out_valid), 64'd1);
    check("t3b_value", 64'(bus.out_value), 64'h000000FF);
    check("t3b_len", 64'(bus.out_len), 64'd1);
    check("t3b_early", 64'(bus.out_early), 64'd0);
    ack();

    // gaps, and stop on the 2^L-th bit
    start_conv(1'b0, 4'd2);
    drive_bit(4'b0011, 1'b1, 1'b0);
    drive_bit(4'b1111, 1'b0, 1'b0);
    drive_bit(4'b0011, 1'b1, 1'b0);
    drive_bit(4'b1111, 1'b0, 1'b0);
    drive_bit(4'b1111, 1'b0, 1'b0);
    drive_bit(4'b0010, 1'b1, 1'b0);
    check("t4_not_yet", 64'(bus.out_valid), 64'd0);
    drive_bit(4'b0011, 1'b1, 1'b1);
    check("t4_valid", 64'(bus.out_valid), 64'd1);
    check("t4_value", 64'(bus.out_value), 64'h0000FFC0);
    check("t4_len", 64'(bus.out_len), 64'd4);
    check("t4_early", 64'(bus.out_early), 64'd0);

    // back-to-back restart in PP, then stop at n=0
    bus.out_ready = 1'b1;
    start_conv(1'b1, 4'd15);
    bus.out_ready = 1'b0;
    check("t5_busy", 64'(bus.busy), 64'd1);
    check("t5_valid_lo", 64'(bus.out_valid), 64'd0);
    drive_bit(4'b1111, 1'b0, 1'b1);
    check("t5_valid", 64'(bus.out_valid), 64'd1);
    check("t5_value", 64'(bus.out_value), 64'd0);
    check("t5_len", 64'(bus.out_len), 64'd0);
    check("t5_early", 64'(bus.out_early), 64'd1);

    // len_log2=15 clamps to 8 -> 256 bits
    bus.out_ready = 1'b1;
    start_conv(1'b0, 4'd15);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b = {2'b00, i[0], 1'b1};
      drive_bit(b, 1'b1, 1'b0);
      if (i == 254) check("t6_not_yet", 64'(bus.out_valid), 64'd0);
    end
    check("t6_valid", 64'(bus.out_valid), 64'd1);
    check("t6_value", 64'(bus.out_value), 64'h000080FF);
    check("t6_len", 64'(bus.out_len), 64'd256);
    ack();

    // asynchronous reset mid-RUN, then a clean conversion
    start_conv(1'b0, 4'd4);
    drive_bit(4'b1111, 1'b1, 1'b0);
    drive_bit(4'b1111, 1'b1, 1'b0);
    drive_bit(4'b1111, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    check("t7_busy", 64'(bus.busy), 64'd0);
    check("t7_valid", 64'(bus.out_valid), 64'd0);
    check("t7_value", 64'(bus.out_value), 64'd0);
    check("t7_len", 64'(bus.out_len), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_conv(1'b0, 4'd1);
    drive_bit(4'b0001, 1'b1, 1'b0);
    drive_bit(4'b0000, 1'b1, 1'b0);
    check("t7b_valid", 64'(bus.out_valid), 64'd1);
    check("t7b_value", 64'(bus.out_value), 64'h00000080);
    check("t7b_len", 64'(bus.out_len), 64'd2);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
